// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: holds the EX->MEM bundle, waits for data SRAM responses,
// aligns/extends load data, buffers responses across WB stalls and drops stale ones.
module mem_stage_hs #(
    parameter int PC_W      = 32,
    parameter int DATA_W    = 32,
    parameter int RF_ADDR_W = 5,
    localparam int IN_W     = PC_W + 6 + RF_ADDR_W + DATA_W,
    localparam int WB_W     = PC_W + 1 + RF_ADDR_W + DATA_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 EX_valid,
    input  logic [IN_W-1:0]      EX_signal,
    output logic                 MEM_allowin,
    input  logic                 data_sram_data_ok,
    input  logic [DATA_W-1:0]    data_sram_rdata,
    input  logic                 WB_allowin,
    output logic                 WB_signal_valid,
    output logic [WB_W-1:0]      WB_signal,
    output logic                 ld_MEM,
    output logic                 MEM_fwd_we,
    output logic [RF_ADDR_W-1:0] MEM_fwd_waddr,
    output logic [DATA_W-1:0]    MEM_fwd_data
);
    localparam int OFF = $clog2(DATA_W / 8);
    localparam logic [OFF-1:0] HALF_MASK = {OFF{1'b1}} << 1;
    localparam logic [OFF-1:0] WORD_MASK = {OFF{1'b1}} << 2;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_BU = 3'b010;
    localparam logic [2:0] LD_H  = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [2:0]           ld_op;
        logic                 mem_req;
        logic                 res_from_mem;
        logic                 rf_we;
        logic [RF_ADDR_W-1:0] rf_waddr;
        logic [DATA_W-1:0]    alu_result;
    } bundle_t;

    bundle_t           bundle_r;
    logic              valid_r;
    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;
    logic [1:0]        drop_cnt;

    logic              resp_ok;
    logic              readygo;
    logic              leave;
    logic              buf_fill;
    logic              drop_inc;
    logic              drop_dec;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] aligned;
    logic [DATA_W-1:0] final_result;
    logic [OFF-1:0]    off;
    logic [DATA_W-1:0] sh_b;
    logic [DATA_W-1:0] sh_h;
    logic [DATA_W-1:0] sh_w;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       word_v;

    // A response only belongs to the current entry once all stale ones are drained.
    assign resp_ok  = data_sram_data_ok & (drop_cnt == 2'd0);
    assign readygo  = !bundle_r.mem_req | buf_valid | resp_ok;
    assign leave    = valid_r & readygo & WB_allowin;
    assign buf_fill = resp_ok & valid_r & bundle_r.mem_req & !WB_allowin & !buf_valid;

    // A flushed request still owes a response unless it already arrived (buffered or this cycle).
    assign drop_inc = flush & valid_r & bundle_r.mem_req & !buf_valid & !resp_ok;
    assign drop_dec = data_sram_data_ok & (drop_cnt != 2'd0);

    assign MEM_allowin = !valid_r | (readygo & WB_allowin);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_r   <= 1'b0;
            buf_valid <= 1'b0;
            drop_cnt  <= 2'd0;
        end else begin
            if (flush)
                valid_r <= 1'b0;
            else if (MEM_allowin)
                valid_r <= EX_valid;

            if (flush || leave)
                buf_valid <= 1'b0;
            else if (buf_fill)
                buf_valid <= 1'b1;

            if (drop_inc && !drop_dec && drop_cnt != 2'd3)
                drop_cnt <= drop_cnt + 2'd1;
            else if (drop_dec && !drop_inc)
                drop_cnt <= drop_cnt - 2'd1;
        end
    end

    // Payload registers carry no reset; valid_r/buf_valid qualify them.
    always_ff @(posedge clk) begin
        if (!flush && MEM_allowin && EX_valid)
            bundle_r <= bundle_t'(EX_signal);
        if (buf_fill)
            buf_data <= data_sram_rdata;
    end

    assign raw  = buf_valid ? buf_data : data_sram_rdata;
    assign off  = bundle_r.alu_result[OFF-1:0];
    assign sh_b = raw >> {off, 3'b000};
    assign sh_h = raw >> {off & HALF_MASK, 3'b000};
    assign sh_w = raw >> {off & WORD_MASK, 3'b000};

    assign byte_v = sh_b[7:0];
    assign half_v = sh_h[15:0];
    assign word_v = sh_w[31:0];

    always_comb begin
        aligned = DATA_W'($signed(word_v));
        case (bundle_r.ld_op)
            LD_B:    aligned = {{(DATA_W-8){byte_v[7]}}, byte_v};
            LD_BU:   aligned = {{(DATA_W-8){1'b0}}, byte_v};
            LD_H:    aligned = {{(DATA_W-16){half_v[15]}}, half_v};
            LD_HU:   aligned = {{(DATA_W-16){1'b0}}, half_v};
            LD_W:    aligned = DATA_W'($signed(word_v));
            default: aligned = DATA_W'($signed(word_v));
        endcase
    end

    assign final_result = bundle_r.res_from_mem ? aligned : bundle_r.alu_result;

    assign WB_signal_valid = valid_r & readygo & !flush;
    assign WB_signal       = {bundle_r.pc, bundle_r.rf_we, bundle_r.rf_waddr, final_result};

    assign ld_MEM        = valid_r & bundle_r.res_from_mem & !readygo;
    assign MEM_fwd_we    = valid_r & bundle_r.rf_we & readygo;
    assign MEM_fwd_waddr = bundle_r.rf_waddr;
    assign MEM_fwd_data  = final_result;
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: ALU pass-through, load alignment, WB-stall buffering,
// flush drop accounting, stores and mid-wait reset.
module tb_mem_stage_hs;
    localparam int PC_W = 32, DATA_W = 32, RF_ADDR_W = 5;
    localparam int IN_W = PC_W + 6 + RF_ADDR_W + DATA_W;
    localparam int WB_W = PC_W + 1 + RF_ADDR_W + DATA_W;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 flush;
    logic                 EX_valid;
    logic [IN_W-1:0]      EX_signal;
    logic                 MEM_allowin;
    logic                 data_sram_data_ok;
    logic [DATA_W-1:0]    data_sram_rdata;
    logic                 WB_allowin;
    logic                 WB_signal_valid;
    logic [WB_W-1:0]      WB_signal;
    logic                 ld_MEM;
    logic                 MEM_fwd_we;
    logic [RF_ADDR_W-1:0] MEM_fwd_waddr;
    logic [DATA_W-1:0]    MEM_fwd_data;

    int vectors = 0;
    int miscompares = 0;

    mem_stage_hs #(.PC_W(PC_W), .DATA_W(DATA_W), .RF_ADDR_W(RF_ADDR_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .EX_valid(EX_valid), .EX_signal(EX_signal), .MEM_allowin(MEM_allowin),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .WB_allowin(WB_allowin), .WB_signal_valid(WB_signal_valid), .WB_signal(WB_signal),
        .ld_MEM(ld_MEM), .MEM_fwd_we(MEM_fwd_we), .MEM_fwd_waddr(MEM_fwd_waddr),
        .MEM_fwd_data(MEM_fwd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [IN_W-1:0] mk(input logic [31:0] pc, input logic [2:0] op,
                                           input logic req, input logic rfm, input logic we,
                                           input logic [4:0] wa, input logic [31:0] alu);
        return {pc, op, req, rfm, we, wa, alu};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1ns after the edge; outputs are checked 1ns after that.
    task automatic settle();
        #1;
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; EX_valid = 1'b0; EX_signal = '0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0; WB_allowin = 1'b1;
        tick(); tick();
        settle();
        chk("rst_wbv", 64'(WB_signal_valid), 64'd0);
        chk("rst_ldm", 64'(ld_MEM), 64'd0);
        chk("rst_fwe", 64'(MEM_fwd_we), 64'd0);
        chk("rst_alw", 64'(MEM_allowin), 64'd1);
        resetn = 1'b1;
        tick();

        // ALU op passes straight through
        EX_valid = 1'b1; EX_signal = mk(32'h100, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234);
        tick();
        EX_valid = 1'b0;
        settle();
        chk("alu_wbv", 64'(WB_signal_valid), 64'd1);
        chk("alu_res", 64'(WB_signal[31:0]), 64'h1234);
        chk("alu_fwe", 64'(MEM_fwd_we), 64'd1);
        chk("alu_fwa", 64'(MEM_fwd_waddr), 64'd5);
        chk("alu_pc", 64'(WB_signal[WB_W-1 -: 32]), 64'h100);
        chk("alu_ldm", 64'(ld_MEM), 64'd0);
        tick();

        // LB at offset 3
        EX_valid = 1'b1; EX_signal = mk(32'h104, 3'b001, 1'b1, 1'b1, 1'b1, 5'd7, 32'h1003);
        tick();
        EX_valid = 1'b0;
        settle();
        chk("lb_ldm", 64'(ld_MEM), 64'd1);
        chk("lb_wbv0", 64'(WB_signal_valid), 64'd0);
        chk("lb_alw0", 64'(MEM_allowin), 64'd0);
        chk("lb_fwe0", 64'(MEM_fwd_we), 64'd0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_0000;
        settle();
        chk("lb_wbv1", 64'(WB_signal_valid), 64'd1);
        chk("lb_res", 64'(WB_signal[31:0]), 64'hFFFF_FF80);
        chk("lb_ldm1", 64'(ld_MEM), 64'd0);
        tick();
        data_sram_data_ok = 1'b0;

        // LBU at offset 3
        EX_valid = 1'b1; EX_signal = mk(32'h108, 3'b010, 1'b1, 1'b1, 1'b1, 5'd7, 32'h1003);
        tick();
        EX_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_0000;
        settle();
        chk("lbu_res", 64'(WB_signal[31:0]), 64'h0000_0080);
        tick();
        data_sram_data_ok = 1'b0;

        // LH at offset 2, WB stalled for 3 cycles
        EX_valid = 1'b1; EX_signal = mk(32'h10C, 3'b011, 1'b1, 1'b1, 1'b1, 5'd8, 32'h2002);
        tick();
        EX_valid = 1'b0; WB_allowin = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7FFE_1234;
        settle();
        chk("lh_alw0", 64'(MEM_allowin), 64'd0);
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'hAAAA_AAAA;
        settle();
        chk("lh_alw1", 64'(MEM_allowin), 64'd0);
        chk("lh_buf1", 64'(WB_signal[31:0]), 64'h0000_7FFE);
        tick();
        settle();
        chk("lh_alw2", 64'(MEM_allowin), 64'd0);
        chk("lh_ldm2", 64'(ld_MEM), 64'd0);
        tick();
        WB_allowin = 1'b1;
        settle();
        chk("lh_alw3", 64'(MEM_allowin), 64'd1);
        chk("lh_res", 64'(WB_signal[31:0]), 64'h0000_7FFE);
        chk("lh_wbv", 64'(WB_signal_valid), 64'd1);
        tick();
        settle();
        chk("lh_gone", 64'(WB_signal_valid), 64'd0);

        // HU and H at offset 2 with negative half
        EX_valid = 1'b1; EX_signal = mk(32'h110, 3'b100, 1'b1, 1'b1, 1'b1, 5'd9, 32'h2002);
        tick();
        EX_valid = 1'b1; EX_signal = mk(32'h114, 3'b011, 1'b1, 1'b1, 1'b1, 5'd9, 32'h2000);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_C003;
        settle();
        chk("hu_res", 64'(WB_signal[31:0]), 64'h0000_8001);
        tick();
        EX_valid = 1'b0;
        settle();
        chk("h_res", 64'(WB_signal[31:0]), 64'hFFFF_C003);
        tick();
        data_sram_data_ok = 1'b0;

        // Flush a waiting LW; the stale response must be dropped
        EX_valid = 1'b1; EX_signal = mk(32'h118, 3'b000, 1'b1, 1'b1, 1'b1, 5'd10, 32'h3000);
        tick();
        EX_valid = 1'b0; flush = 1'b1;
        settle();
        chk("fl_wbv", 64'(WB_signal_valid), 64'd0);
        tick();
        flush = 1'b0;
        EX_valid = 1'b1; EX_signal = mk(32'h11C, 3'b000, 1'b1, 1'b1, 1'b1, 5'd11, 32'h3004);
        settle();
        chk("fl_alw", 64'(MEM_allowin), 64'd1);
        tick();
        EX_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_DEAD;
        settle();
        chk("fl_drop_wbv", 64'(WB_signal_valid), 64'd0);
        chk("fl_drop_ldm", 64'(ld_MEM), 64'd1);
        tick();
        data_sram_rdata = 32'h0000_BEEF;
        settle();
        chk("fl_new_wbv", 64'(WB_signal_valid), 64'd1);
        chk("fl_new_res", 64'(WB_signal[31:0]), 64'h0000_BEEF);
        tick();
        data_sram_data_ok = 1'b0;

        // Response arriving with the flush is consumed, nothing left to drop
        EX_valid = 1'b1; EX_signal = mk(32'h120, 3'b000, 1'b1, 1'b1, 1'b1, 5'd12, 32'h4000);
        tick();
        EX_valid = 1'b0; flush = 1'b1;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
        tick();
        flush = 1'b0; data_sram_data_ok = 1'b0;
        EX_valid = 1'b1; EX_signal = mk(32'h124, 3'b000, 1'b1, 1'b1, 1'b1, 5'd13, 32'h4004);
        tick();
        EX_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_0055;
        settle();
        chk("flok_wbv", 64'(WB_signal_valid), 64'd1);
        chk("flok_res", 64'(WB_signal[31:0]), 64'h0000_0055);
        tick();
        data_sram_data_ok = 1'b0;

        // Store waits for data_ok but is not a load
        EX_valid = 1'b1; EX_signal = mk(32'h128, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h5000);
        tick();
        EX_valid = 1'b0;
        settle();
        chk("st_wbv0", 64'(WB_signal_valid), 64'd0);
        chk("st_ldm", 64'(ld_MEM), 64'd0);
        chk("st_alw0", 64'(MEM_allowin), 64'd0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h9999_9999;
        settle();
        chk("st_wbv1", 64'(WB_signal_valid), 64'd1);
        chk("st_res", 64'(WB_signal[31:0]), 64'h0000_5000);
        tick();
        data_sram_data_ok = 1'b0;

        // Reset in the middle of a load wait
        EX_valid = 1'b1; EX_signal = mk(32'h12C, 3'b000, 1'b1, 1'b1, 1'b1, 5'd14, 32'h6000);
        tick();
        EX_valid = 1'b0;
        settle();
        chk("rw_ldm0", 64'(ld_MEM), 64'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        settle();
        chk("rw_wbv", 64'(WB_signal_valid), 64'd0);
        chk("rw_ldm", 64'(ld_MEM), 64'd0);
        chk("rw_alw", 64'(MEM_allowin), 64'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
